inta_sequencer: RTL and testbench
=================================

# inta_sequencer

CPU-side interrupt-acknowledge master for the 8259-compatible controller. Watches the controller's INT line and, when interrupts are enabled, drives the two-pulse INTA sequence and captures the 8-bit vector off the data bus during the second pulse. It then hands the vector to the core over a valid/ready handshake and, on request, issues the OCW2 end-of-interrupt write (A0=0, RD_n=1, WR_n pulse) that closes the service.

## Interface
Parameters:
- T_LOW, 4, cycles INTA_n/WR_n held low per pulse (≥1)
- T_GAP, 2, cycles INTA_n held high between the two pulses, and after the EOI pulse (≥1)

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- INT  in  1  interrupt request from controller (asynchronous to CLK)
- IEN  in  1  CPU interrupt-enable flag
- DIN  in  8  data bus input (vector during 2nd INTA pulse)
- INTA_n  out  1  acknowledge strobe to controller, active low
- WR_n  out  1  write strobe for the EOI command, active low
- A0  out  1  register select for the command write, always 0
- DOUT  out  8  command byte driven during the EOI write
- DOE  out  1  data-bus output enable; high only while WR_n is low
- VEC  out  8  captured vector
- VEC_VALID  out  1  VEC holds an unconsumed vector
- VEC_READY  in  1  core accepts VEC
- EOI_REQ  in  1  one-cycle request to send EOI
- EOI_SPEC  in  1  1 = specific EOI, 0 = non-specific
- EOI_LVL  in  3  IR level for specific EOI
- BUSY  out  1  high in every state except IDLE

## Operation
- INT passes through a 2-flop synchronizer (INT_s) before use.
- States:
  - IDLE
  - A1_LO (INTA_n=0)
  - A1_GAP (INTA_n=1)
  - A2_LO (INTA_n=0)
  - HOLD (VEC_VALID=1)
  - SERVICE (waiting for EOI_REQ)
  - E_WR (WR_n=0, DOE=1)
  - E_GAP (strobes high)
- Transitions:
  - IDLE→A1_LO when INT_s && IEN.
  - A1_LO→A1_GAP after T_LOW cycles.
  - A1_GAP→A2_LO after T_GAP cycles.
  - A2_LO→HOLD after T_LOW cycles. VEC←DIN is sampled on the last A2_LO cycle.
  - HOLD→SERVICE on the cycle VEC_VALID && VEC_READY.
  - SERVICE→E_WR when EOI_REQ=1.
  - E_WR→E_GAP after T_LOW cycles.
  - E_GAP→IDLE after T_GAP cycles.
- Once A1_LO is entered, the sequence completes regardless of INT_s or IEN. If INT has dropped, the controller supplies its default vector, and that vector is still captured and delivered.
- EOI_REQ is ignored outside SERVICE; it is not queued.
- Command byte, held stable for all of E_WR:
  - non-specific: DOUT=8'h20 (OCW2 R=0, SL=0, EOI=1)
  - specific: DOUT=8'h60 | EOI_LVL
- Outside E_WR: DOUT=0, DOE=0.
- One down-counter, sized for max(T_LOW, T_GAP), is reloaded on every state entry.
- VEC holds its value until the next capture.
- VEC_VALID clears on handshake. It never rises outside A2_LO→HOLD.
- A new INT is not acknowledged until the FSM returns to IDLE. This covers HOLD, SERVICE, E_WR and E_GAP.

## Timing
- Reset values: INTA_n=1, WR_n=1, A0=0, DOUT=8'h00, DOE=0, VEC=8'h00, VEC_VALID=0, BUSY=0. State=IDLE, synchronizer cleared.
- RST asserted mid-sequence forces INTA_n/WR_n high and DOE low immediately (asynchronously). No partial pulse resumes after release.
- Latency from INT rising (setup met) to the first INTA_n low: 3 cycles (2 sync + 1 transition).
- INTA_n pattern: T_LOW low, T_GAP high, T_LOW low, then high.
- Capture to VEC_VALID: VEC_VALID rises on the edge that ends A2_LO, together with INTA_n rising.
- Handshake: the transfer occurs on a rising edge with VEC_VALID && VEC_READY. VEC_READY high in the first HOLD cycle gives 1-cycle HOLD.
- EOI_REQ seen in SERVICE → WR_n low the next cycle, for exactly T_LOW cycles.
- BUSY falls on the edge leaving E_GAP. The earliest re-ack (INT_s already high) starts the next cycle.
- INTA_n and WR_n are never low in the same cycle.

## Test plan
- Defaults: INT rises, IEN=1, DIN=8'h4B during A2_LO → INTA_n low on cycles 3–6, high 7–8, low 9–12. VEC=8'h4B and VEC_VALID=1 from cycle 13.
- IEN=0 with INT held high for 50 cycles → INTA_n stays 1 and BUSY=0. IEN→1 → sequence starts 1 cycle later.
- VEC_READY held low for 10 cycles in HOLD → VEC_VALID stays 1 with VEC stable. Raise VEC_READY → VEC_VALID=0 and state is SERVICE the following cycle.
- EOI: EOI_REQ with EOI_SPEC=0 → WR_n low for 4 cycles, DOUT=8'h20, A0=0, DOE=1. With EOI_SPEC=1, EOI_LVL=5 → DOUT=8'h65. EOI_REQ pulsed in IDLE → no WR_n activity.
- INT drops during A1_GAP → second pulse still issued, DIN=8'h3F captured, VEC_VALID=1.
- RST pulsed during A2_LO → INTA_n=1 and all outputs at reset values within the same cycle. After release with INT high → fresh sequence starts after 3 cycles.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: CPU-side interrupt-acknowledge master for an 8259-compatible
// controller. Issues the two-pulse INTA sequence, captures the vector, hands it
// to the core over valid/ready, then writes the OCW2 end-of-interrupt command.
module inta_sequencer #(
    parameter int unsigned T_LOW = 4,
    parameter int unsigned T_GAP = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INT,
    input  logic       IEN,
    input  logic [7:0] DIN,
    output logic       INTA_n,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic [7:0] VEC,
    output logic       VEC_VALID,
    input  logic       VEC_READY,
    input  logic       EOI_REQ,
    input  logic       EOI_SPEC,
    input  logic [2:0] EOI_LVL,
    output logic       BUSY
);

    localparam int unsigned CMAX = (T_LOW > T_GAP) ? T_LOW : T_GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] LOW_LD = CW'(T_LOW - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(T_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        A1_LO,
        A1_GAP,
        A2_LO,
        HOLD,
        SERVICE,
        E_WR,
        E_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          int_meta;
    logic          int_s;
    logic [7:0]    cmd;

    // Command register select is always the OCW2 address.
    assign A0 = 1'b0;

    // OCW2 byte: non-specific EOI, or specific EOI for the given IR level.
    always_comb begin
        cmd = 8'h20;
        if (EOI_SPEC) cmd = 8'h60 | {5'b00000, EOI_LVL};
    end

    // Two-flop synchronizer for the asynchronous INT line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
        end
    end

    // Sequencer FSM with registered strobes, vector capture and a shared
    // down-counter reloaded on every state entry (expires at zero).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            INTA_n    <= 1'b1;
            WR_n      <= 1'b1;
            DOE       <= 1'b0;
            DOUT      <= '0;
            VEC       <= '0;
            VEC_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_s && IEN) begin
                        state  <= A1_LO;
                        cnt    <= LOW_LD;
                        INTA_n <= 1'b0;
                        BUSY   <= 1'b1;
                    end
                end
                A1_LO: begin
                    if (cnt == '0) begin
                        state  <= A1_GAP;
                        cnt    <= GAP_LD;
                        INTA_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                A1_GAP: begin
                    if (cnt == '0) begin
                        state  <= A2_LO;
                        cnt    <= LOW_LD;
                        INTA_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                A2_LO: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        INTA_n    <= 1'b1;
                        VEC       <= DIN;
                        VEC_VALID <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (VEC_READY) begin
                        state     <= SERVICE;
                        cnt       <= '0;
                        VEC_VALID <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (EOI_REQ) begin
                        state <= E_WR;
                        cnt   <= LOW_LD;
                        WR_n  <= 1'b0;
                        DOE   <= 1'b1;
                        DOUT  <= cmd;
                    end
                end
                E_WR: begin
                    if (cnt == '0) begin
                        state <= E_GAP;
                        cnt   <= GAP_LD;
                        WR_n  <= 1'b1;
                        DOE   <= 1'b0;
                        DOUT  <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                E_GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed test-plan scenarios followed by randomized
// traffic, all checked cycle by cycle against a phase/timestamp model.
module tb_inta_sequencer;

    localparam int unsigned T_LOW = 4;
    localparam int unsigned T_GAP = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       INT;
    logic       IEN;
    logic [7:0] DIN;
    logic       INTA_n;
    logic       WR_n;
    logic       A0;
    logic [7:0] DOUT;
    logic       DOE;
    logic [7:0] VEC;
    logic       VEC_VALID;
    logic       VEC_READY;
    logic       EOI_REQ;
    logic       EOI_SPEC;
    logic [2:0] EOI_LVL;
    logic       BUSY;

    inta_sequencer #(.T_LOW(T_LOW), .T_GAP(T_GAP)) dut (
        .CLK(CLK), .RST(RST), .INT(INT), .IEN(IEN), .DIN(DIN),
        .INTA_n(INTA_n), .WR_n(WR_n), .A0(A0), .DOUT(DOUT), .DOE(DOE),
        .VEC(VEC), .VEC_VALID(VEC_VALID), .VEC_READY(VEC_READY),
        .EOI_REQ(EOI_REQ), .EOI_SPEC(EOI_SPEC), .EOI_LVL(EOI_LVL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: which phase of the service we are in and how
    // many cycles have elapsed in it; strobes follow from elapsed time.
    typedef enum {M_IDLE, M_ACK, M_HOLD, M_SERV, M_EOI} mphase_t;
    mphase_t     m_phase;
    int unsigned m_age;
    logic        m_s0, m_s1;
    logic [7:0]  m_vec;
    logic        m_valid;
    logic [7:0]  m_cmd;

    function automatic void model_reset();
        m_phase = M_IDLE;
        m_age   = 0;
        m_s0    = 1'b0;
        m_s1    = 1'b0;
        m_vec   = 8'h00;
        m_valid = 1'b0;
        m_cmd   = 8'h00;
    endfunction

    // Advance the model across one rising edge using the inputs present at it.
    function automatic void model_step();
        logic seen;
        if (RST) begin
            model_reset();
            return;
        end
        seen = m_s1;
        m_s1 = m_s0;
        m_s0 = INT;
        case (m_phase)
            M_IDLE: if (seen && IEN) begin m_phase = M_ACK; m_age = 0; end
            M_ACK: begin
                if (m_age == 2 * T_LOW + T_GAP - 1) begin
                    m_vec   = DIN;
                    m_valid = 1'b1;
                    m_phase = M_HOLD;
                end else m_age++;
            end
            M_HOLD: if (VEC_READY) begin m_valid = 1'b0; m_phase = M_SERV; end
            M_SERV: begin
                if (EOI_REQ) begin
                    m_phase = M_EOI;
                    m_age   = 0;
                    m_cmd   = EOI_SPEC ? (8'h60 + {5'b00000, EOI_LVL}) : 8'h20;
                end
            end
            M_EOI: if (m_age == T_LOW + T_GAP - 1) m_phase = M_IDLE; else m_age++;
            default: m_phase = M_IDLE;
        endcase
    endfunction

    function automatic logic exp_inta_n();
        return !(m_phase == M_ACK && (m_age < T_LOW || m_age >= T_LOW + T_GAP));
    endfunction

    function automatic logic exp_wr_n();
        return !(m_phase == M_EOI && m_age < T_LOW);
    endfunction

    task automatic compare_all();
        check("inta_n", INTA_n, exp_inta_n());
        check("wr_n", WR_n, exp_wr_n());
        check("a0", A0, 1'b0);
        check("doe", DOE, !exp_wr_n());
        check("dout", DOUT, !exp_wr_n() ? m_cmd : 8'h00);
        check("vec", VEC, m_vec);
        check("vec_valid", VEC_VALID, m_valid);
        check("busy", BUSY, m_phase != M_IDLE);
    endtask

    // One clock: edge, model update, sample 1 ns later.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_async_inta_n", INTA_n, 1'b1);
        check("rst_async_wr_n", WR_n, 1'b1);
        check("rst_async_doe", DOE, 1'b0);
        check("rst_async_dout", DOUT, 8'h00);
        check("rst_async_valid", VEC_VALID, 1'b0);
        check("rst_async_busy", BUSY, 1'b0);
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        int n;
        int wr_low;
        bit reached;

        RST = 1'b1; INT = 1'b0; IEN = 1'b1; DIN = 8'h00;
        VEC_READY = 1'b0; EOI_REQ = 1'b0; EOI_SPEC = 1'b0; EOI_LVL = 3'd0;
        model_reset();
        repeat (2) cycle();
        check("reset_vec", VEC, 8'h00);
        check("reset_a0", A0, 1'b0);
        RST = 1'b0;
        repeat (3) cycle();

        // Default acknowledge: latency, capture, held vector, handshake.
        DIN = 8'h4B;
        INT = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (INTA_n !== 1'b0 && n < 10);
        check("ack_latency", 8'(n), 8'd3);
        repeat (10) cycle();
        check("dflt_vec", VEC, 8'h4B);
        check("dflt_valid", VEC_VALID, 1'b1);
        repeat (10) begin
            cycle();
            check("hold_valid", VEC_VALID, 1'b1);
            check("hold_vec", VEC, 8'h4B);
        end
        VEC_READY = 1'b1;
        cycle();
        VEC_READY = 1'b0;
        check("hs_valid", VEC_VALID, 1'b0);
        check("hs_busy", BUSY, 1'b1);

        // Non-specific EOI.
        INT = 1'b0;
        EOI_REQ = 1'b1; EOI_SPEC = 1'b0;
        cycle();
        EOI_REQ = 1'b0;
        check("eoi_ns_wr_n", WR_n, 1'b0);
        check("eoi_ns_dout", DOUT, 8'h20);
        check("eoi_ns_doe", DOE, 1'b1);
        wr_low = 1;
        repeat (8) begin cycle(); if (WR_n === 1'b0) wr_low++; end
        check("eoi_width", 8'(wr_low), 8'(T_LOW));
        check("eoi_done_busy", BUSY, 1'b0);

        // EOI_REQ in IDLE is ignored.
        EOI_REQ = 1'b1;
        cycle();
        EOI_REQ = 1'b0;
        check("eoi_idle_wr_n", WR_n, 1'b1);
        repeat (3) cycle();

        // Specific EOI, level 5.
        DIN = 8'h91;
        INT = 1'b1;
        repeat (14) cycle();
        VEC_READY = 1'b1;
        cycle();
        VEC_READY = 1'b0;
        INT = 1'b0;
        EOI_REQ = 1'b1; EOI_SPEC = 1'b1; EOI_LVL = 3'd5;
        cycle();
        EOI_REQ = 1'b0;
        check("eoi_spec_dout", DOUT, 8'h65);
        repeat (8) cycle();

        // Interrupts disabled with INT high, then enabled.
        IEN = 1'b0;
        INT = 1'b1;
        repeat (50) cycle();
        check("ien0_inta_n", INTA_n, 1'b1);
        check("ien0_busy", BUSY, 1'b0);
        IEN = 1'b1;
        cycle();
        check("ien1_inta_n", INTA_n, 1'b0);

        // INT withdrawn during the gap: sequence still completes.
        repeat (4) cycle();
        INT = 1'b0;
        DIN = 8'h3F;
        repeat (12) cycle();
        check("drop_vec", VEC, 8'h3F);
        check("drop_valid", VEC_VALID, 1'b1);
        VEC_READY = 1'b1;
        cycle();
        VEC_READY = 1'b0;
        EOI_REQ = 1'b1; EOI_SPEC = 1'b0;
        cycle();
        EOI_REQ = 1'b0;
        repeat (8) cycle();

        // Reset in the middle of the second pulse, INT held high.
        INT = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            cycle();
            if (m_phase == M_ACK && m_age == T_LOW + T_GAP + 1) reached = 1'b1;
        end
        check("a2_reached", reached, 1'b1);
        check("a2_inta_n", INTA_n, 1'b0);
        pulse_reset();
        n = 0;
        do begin cycle(); n++; end while (INTA_n !== 1'b0 && n < 10);
        check("rst_reack_latency", 8'(n), 8'd3);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) INT = ~INT;
            IEN       = ($urandom_range(0, 9) != 0);
            DIN       = 8'($urandom);
            VEC_READY = ($urandom_range(0, 2) == 0);
            EOI_REQ   = ($urandom_range(0, 5) == 0);
            EOI_SPEC  = 1'($urandom);
            EOI_LVL   = 3'($urandom);
            if ($urandom_range(0, 599) == 0) pulse_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
